// File: rtl/floo_pkg.sv
// Shared types for the FlooNoC output arbiter: FSM state encoding and the
// default flit layout carrying the header `last` marker.
package floo_pkg;

    typedef enum logic {
        ArbIdle,
        ArbLocked
    } arb_state_e;

    typedef struct packed {
        logic       last;
        logic [2:0] src_id;
    } floo_hdr_t;

    typedef struct packed {
        floo_hdr_t  hdr;
        logic [7:0] payload;
    } floo_flit_t;

endpackage

// File: rtl/floo_out_reg.sv
// Single-entry valid/ready pipeline register. Drain and load in the same
// cycle keeps the entry full, so one flit per cycle flows through.
module floo_out_reg #(
    parameter type flit_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  valid_i,
    output logic  ready_o,
    input  flit_t data_i,
    output logic  valid_o,
    input  logic  ready_i,
    output flit_t data_o
);

    logic  valid_q;
    flit_t data_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (valid_i && ready_o) begin
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/floo_output_arbiter.sv
// Per-output-port wormhole arbiter: round-robin grant among router inputs,
// held from header flit to the flit with hdr.last, with optional output register.
module floo_output_arbiter
    import floo_pkg::*;
#(
    parameter int unsigned NumInputs   = 5,
    parameter type         flit_t      = floo_pkg::floo_flit_t,
    parameter bit          LockRouting = 1'b1,
    parameter bit          OutReg      = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumInputs-1:0]  valid_i,
    output logic [NumInputs-1:0]  ready_o,
    input  flit_t [NumInputs-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output flit_t                 data_o,
    output logic [NumInputs-1:0]  grant_o,
    output logic                  locked_o
);

    localparam int unsigned PtrW = (NumInputs > 1) ? $clog2(NumInputs) : 1;

    arb_state_e      state_q;
    logic [PtrW-1:0] rr_ptr_q;
    logic [PtrW-1:0] owner_q;

    logic [PtrW-1:0] pick;
    logic [PtrW-1:0] sel_idx;
    flit_t           sel_data;
    logic            in_valid;
    logic            out_ready;
    logic            xfer;
    logic            sel_last;

    // Descending scan so the smallest offset from ptr is the last assignment and wins.
    function automatic logic [PtrW-1:0] rr_search(input logic [NumInputs-1:0] req,
                                                  input logic [PtrW-1:0]      ptr);
        logic [PtrW-1:0] res;
        res = ptr;
        for (int unsigned i = NumInputs; i > 0; i--) begin
            int unsigned idx;
            idx = (int'(ptr) + i - 1) % NumInputs;
            if (req[idx]) res = PtrW'(idx);
        end
        return res;
    endfunction

    function automatic logic [PtrW-1:0] rr_next(input logic [PtrW-1:0] k);
        return (k == PtrW'(NumInputs - 1)) ? '0 : k + 1'b1;
    endfunction

    assign pick    = rr_search(valid_i, rr_ptr_q);
    assign sel_idx = (state_q == ArbLocked) ? owner_q : pick;

    always_comb begin
        grant_o = '0;
        if (!rst_i) begin
            if (state_q == ArbLocked) begin
                grant_o[owner_q] = 1'b1;
            end else if (|valid_i) begin
                grant_o[pick] = 1'b1;
            end
        end
    end

    assign sel_data = data_i[sel_idx];
    assign sel_last = sel_data.hdr.last;
    assign in_valid = |(valid_i & grant_o);
    assign ready_o  = grant_o & {NumInputs{out_ready}};
    assign xfer     = in_valid && out_ready;
    assign locked_o = (state_q == ArbLocked);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ArbIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            case (state_q)
                ArbIdle: begin
                    if (xfer) begin
                        if (LockRouting && !sel_last) begin
                            state_q <= ArbLocked;
                            owner_q <= pick;
                        end else begin
                            rr_ptr_q <= rr_next(pick);
                        end
                    end
                end
                ArbLocked: begin
                    if (xfer && sel_last) begin
                        state_q  <= ArbIdle;
                        rr_ptr_q <= rr_next(owner_q);
                    end
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

    if (OutReg) begin : gen_out_reg
        floo_out_reg #(
            .flit_t (flit_t)
        ) i_out_reg (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (in_valid),
            .ready_o (out_ready),
            .data_i  (sel_data),
            .valid_o (valid_o),
            .ready_i (ready_i),
            .data_o  (data_o)
        );
    end else begin : gen_pass
        assign valid_o   = in_valid;
        assign out_ready = ready_i;
        assign data_o    = sel_data;
    end

`ifndef SYNTHESIS
    for (genvar i = 0; i < NumInputs; i++) begin : gen_hold_chk
        assert property (@(posedge clk_i) disable iff (rst_i)
            (state_q == ArbIdle && valid_i[i] && !ready_o[i]) |=> valid_i[i])
        else $error("request on input %0d withdrawn before transfer", i);
    end
`endif

endmodule

// File: tb/tb_floo_output_arbiter.sv
// Scoreboard bench for floo_output_arbiter: a locked/registered instance and
// an unlocked/pass-through instance share one driver selected by `sel`.
module tb_floo_output_arbiter;
    import floo_pkg::*;

    localparam int unsigned NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 sel;
    logic                 ready_i;
    logic [NI-1:0]        drv_valid;
    floo_flit_t [NI-1:0]  drv_data;

    logic [NI-1:0] valid_a, valid_b, ready_a, ready_b, grant_a, grant_b;
    logic          vo_a, vo_b, lk_a, lk_b;
    floo_flit_t    do_a, do_b;

    logic [NI-1:0] act_ready, act_grant;
    logic          act_vo, act_lk;
    floo_flit_t    act_do;

    assign valid_a   = sel ? '0 : drv_valid;
    assign valid_b   = sel ? drv_valid : '0;
    assign act_ready = sel ? ready_b : ready_a;
    assign act_grant = sel ? grant_b : grant_a;
    assign act_vo    = sel ? vo_b : vo_a;
    assign act_lk    = sel ? lk_b : lk_a;
    assign act_do    = sel ? do_b : do_a;

    floo_output_arbiter #(
        .NumInputs   (NI),
        .flit_t      (floo_flit_t),
        .LockRouting (1'b1),
        .OutReg      (1'b1)
    ) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid_a),
        .ready_o  (ready_a),
        .data_i   (drv_data),
        .valid_o  (vo_a),
        .ready_i  (ready_i),
        .data_o   (do_a),
        .grant_o  (grant_a),
        .locked_o (lk_a)
    );

    floo_output_arbiter #(
        .NumInputs   (NI),
        .flit_t      (floo_flit_t),
        .LockRouting (1'b0),
        .OutReg      (1'b0)
    ) u_dut_nl (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid_b),
        .ready_o  (ready_b),
        .data_i   (drv_data),
        .valid_o  (vo_b),
        .ready_i  (ready_i),
        .data_o   (do_b),
        .grant_o  (grant_b),
        .locked_o (lk_b)
    );

    floo_flit_t    in_q[NI][$];
    floo_flit_t    exp_q[$];
    logic [NI-1:0] xfer;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            out_cnt, first_cyc, last_cyc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic floo_flit_t mk(input int src, input int seq, input bit last);
        floo_flit_t f;
        f.hdr.last   = last;
        f.hdr.src_id = 3'(src);
        f.payload    = 8'(src * 16 + seq);
        return f;
    endfunction

    task automatic send(input int src, input int len);
        for (int s = 0; s < len; s++) in_q[src].push_back(mk(src, s, s == len - 1));
    endtask

    task automatic expect_pkt(input int src, input int first, input int len, input int total);
        for (int s = first; s < first + len; s++) exp_q.push_back(mk(src, s, s == total - 1));
    endtask

    task automatic refresh();
        for (int i = 0; i < NI; i++) begin
            drv_valid[i] = (in_q[i].size() != 0);
            drv_data[i]  = (in_q[i].size() != 0) ? in_q[i][0] : '0;
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NI; i++) n += in_q[i].size();
        return n;
    endfunction

    task automatic sample();
        floo_flit_t e;
        @(negedge clk);
        xfer = drv_valid & act_ready;
        if (!rst && act_vo && ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(act_do), 32'hdead);
            end else begin
                e = exp_q.pop_front();
                check("data_o", 32'(act_do), 32'(e));
                if (out_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                out_cnt++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++)
            if (xfer[i] && in_q[i].size() != 0) void'(in_q[i].pop_front());
        refresh();
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while (pending() != 0 || exp_q.size() != 0) begin
            if (n >= budget) begin
                check({tag, "_timeout"}, 32'(n), 32'(-1));
                break;
            end
            sample();
            advance();
            n++;
        end
        repeat (2) begin
            sample();
            advance();
        end
    endtask

    task automatic start_seq(output int start);
        out_cnt = 0;
        refresh();
        start = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) in_q[i].delete();
        exp_q.delete();
        refresh();
        repeat (2) advance();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        sel     = 1'b0;
        ready_i = 1'b1;
        rst     = 1'b1;
        xfer    = '0;
        out_cnt = 0;
        for (int i = 0; i < NI; i++) in_q[i].delete();
        refresh();

        // Reset state, during and right after reset
        repeat (2) advance();
        sample();
        check("rst_valid_o", 32'(vo_a), 0);
        check("rst_locked_o", 32'(lk_a), 0);
        check("rst_grant_o", 32'(grant_a), 0);
        check("rst_ready_o", 32'(ready_a), 0);
        advance();
        rst = 1'b0;
        sample();
        check("idle_valid_o", 32'(vo_a), 0);
        check("idle_grant_o", 32'(grant_a), 0);
        advance();

        // Single 3-flit packet from input 2, cycle-exact lock tracking
        send(2, 3);
        expect_pkt(2, 0, 3, 3);
        start_seq(start);
        sample();
        check("b_grant_c0", 32'(act_grant), 32'b00100);
        check("b_ready_c0", 32'(act_ready), 32'b00100);
        check("b_locked_c0", 32'(act_lk), 0);
        check("b_valid_c0", 32'(act_vo), 0);
        advance();
        sample();
        check("b_locked_c1", 32'(act_lk), 1);
        advance();
        sample();
        check("b_locked_c2", 32'(act_lk), 1);
        advance();
        sample();
        check("b_locked_c3", 32'(act_lk), 0);
        check("b_grant_c3", 32'(act_grant), 0);
        check("b_drain", 32'(exp_q.size()), 0);
        advance();

        // Pointer now 3: inputs 1 and 4 contend, 4 wins, then 1
        send(1, 1);
        send(4, 1);
        expect_pkt(4, 0, 1, 1);
        expect_pkt(1, 0, 1, 1);
        start_seq(start);
        run("c", 20);
        check("c_count", 32'(out_cnt), 2);
        check("c_gap", 32'(last_cyc - first_cyc + 1), 2);

        // Contention from reset: 0a 0b 3a 3b back to back, one cycle latency
        do_reset();
        send(0, 2);
        send(3, 2);
        expect_pkt(0, 0, 2, 2);
        expect_pkt(3, 0, 2, 2);
        start_seq(start);
        run("d", 20);
        check("d_gap", 32'(last_cyc - first_cyc + 1), 4);
        check("d_latency", 32'(first_cyc - start), 1);

        // Wrap-around: pointer 4, inputs 1 and 4 -> 4 first, then 1
        send(1, 2);
        send(4, 2);
        expect_pkt(4, 0, 2, 2);
        expect_pkt(1, 0, 2, 2);
        start_seq(start);
        run("e", 20);
        check("e_gap", 32'(last_cyc - first_cyc + 1), 4);

        // Backpressure for 4 cycles mid-packet
        send(2, 5);
        expect_pkt(2, 0, 5, 5);
        start_seq(start);
        repeat (2) begin
            sample();
            advance();
        end
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("f_hold_valid", 32'(act_vo), 1);
            check("f_hold_data", 32'(act_do), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hbad);
            check("f_owner_ready", 32'(act_ready), 0);
            advance();
        end
        ready_i = 1'b1;
        run("f", 30);
        check("f_count", 32'(out_cnt), 5);

        // Reset in the middle of a 3-flit packet
        send(2, 3);
        expect_pkt(2, 0, 3, 3);
        start_seq(start);
        sample();
        advance();
        sample();
        advance();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) in_q[i].delete();
        exp_q.delete();
        refresh();
        sample();
        advance();
        rst = 1'b0;
        sample();
        check("g_valid_o", 32'(act_vo), 0);
        check("g_locked_o", 32'(act_lk), 0);
        check("g_grant_o", 32'(act_grant), 0);
        advance();
        send(1, 1);
        send(3, 1);
        expect_pkt(1, 0, 1, 1);
        expect_pkt(3, 0, 1, 1);
        start_seq(start);
        run("g", 20);
        check("g_count", 32'(out_cnt), 2);

        // Lock disabled, pass-through: flits interleave 0,1,0,1 with zero latency
        sel = 1'b1;
        send(0, 2);
        send(1, 2);
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(1, 0, 0));
        exp_q.push_back(mk(0, 1, 1));
        exp_q.push_back(mk(1, 1, 1));
        start_seq(start);
        run("h", 20);
        check("h_gap", 32'(last_cyc - first_cyc + 1), 4);
        check("h_latency", 32'(first_cyc - start), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
